hex_marquee_decoder: RTL



---
 rtl/hex_marquee_decoder_if.sv | 42 ++++
 rtl/hex_marquee_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hex_marquee_decoder_if.sv
// hex_marquee_decoder_if
// Bundles the eight seven-segment digit inputs and the decoded-frame outputs
// of hex_marquee_decoder.
//   HEX7..HEX0   [0:6] active-low segment codes, index 0 = segment a,
//                HEX7 is the leftmost digit
//   CHARS        24-bit decoded frame, CHARS[23:21] = HEX7 .. CHARS[2:0] = HEX0
//   FRAME_VALID  one-cycle pulse per accepted frame
//   STEP         one-cycle pulse when the accepted frame is a one-digit left scroll
//   STEP_COUNT   saturating count of STEP events
//   PERIOD       cycles between the last two STEP events
//   PERIOD_VALID high once two STEP events have been seen
//   ERR          sticky scroll-mismatch flag
//   BADSEG       sticky undecodable-pattern flag
// master: the side driving the segment codes; slave: the decoder.
interface hex_marquee_decoder_if;
    logic [0:6]  HEX7;
    logic [0:6]  HEX6;
    logic [0:6]  HEX5;
    logic [0:6]  HEX4;
    logic [0:6]  HEX3;
    logic [0:6]  HEX2;
    logic [0:6]  HEX1;
    logic [0:6]  HEX0;
    logic [23:0] CHARS;
    logic        FRAME_VALID;
    logic        STEP;
    logic [7:0]  STEP_COUNT;
    logic [31:0] PERIOD;
    logic        PERIOD_VALID;
    logic        ERR;
    logic        BADSEG;

    modport master (
        output HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        input  CHARS, FRAME_VALID, STEP, STEP_COUNT, PERIOD, PERIOD_VALID, ERR, BADSEG
    );

    modport slave (
        input  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        output CHARS, FRAME_VALID, STEP, STEP_COUNT, PERIOD, PERIOD_VALID, ERR, BADSEG
    );
endinterface

// File: rtl/hex_marquee_decoder.sv
// hex_marquee_decoder
// Watches an eight-digit seven-segment display showing a scrolling "HELLO"
// marquee. A frame is accepted once it has been stable for STABLE_CYCLES
// clocks; each accepted frame is decoded to 3-bit character codes and
// classified against the previously accepted frame as HOLD, STEP (one-digit
// left scroll) or MISMATCH. The interval between STEP events is measured.
// Ports:
//   CLOCK_50  sole clock, rising edge
//   RESET     synchronous, active-high
//   bus       hex_marquee_decoder_if.slave (segment inputs, decoded outputs)
module hex_marquee_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    hex_marquee_decoder_if.slave  bus
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] RUN_ACC = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    function automatic logic [2:0] decode_digit(input logic [6:0] seg);
        case (seg)
            7'b1111111: decode_digit = 3'd0;
            7'b1001000: decode_digit = 3'd1;
            7'b0110000: decode_digit = 3'd2;
            7'b1110001: decode_digit = 3'd3;
            7'b0000001: decode_digit = 3'd4;
            default:    decode_digit = 3'd7;
        endcase
    endfunction

    function automatic logic [23:0] decode_frame(input logic [55:0] segs);
        logic [23:0] codes;
        codes = '0;
        for (int k = 0; k < 8; k++) begin
            codes[3*k +: 3] = decode_digit(segs[7*k +: 7]);
        end
        return codes;
    endfunction

    function automatic logic any_invalid(input logic [23:0] codes);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (codes[3*k +: 3] == 3'd7) bad = 1'b1;
        end
        return bad;
    endfunction

    // Digit k moves to position k+1 and the leftmost digit wraps to position 0.
    function automatic logic [23:0] scroll_left(input logic [23:0] codes);
        return {codes[20:0], codes[23:21]};
    endfunction

    logic [55:0] hex_now;
    logic [55:0] smp_p0;
    logic [7:0]  run_p0;
    logic        same;
    logic        accept;
    logic [23:0] decoded;
    logic        decoded_bad;

    state_t      state;
    logic [31:0] cyc;
    logic        seen_step;
    logic [23:0] chars_p1;
    logic        frame_valid_p1;
    logic        step_p1;
    logic [7:0]  step_count_p1;
    logic [31:0] period_p1;
    logic        period_valid_p1;
    logic        err_p1;
    logic        badseg_p1;

    // Concatenation keeps segment a in the MSB of each 7-bit slice.
    assign hex_now = {bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4,
                      bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

    // Acceptance is the edge on which the run counter climbs to STABLE_CYCLES,
    // so it fires once per stable interval and the counter then parks.
    assign same        = (hex_now == smp_p0);
    assign accept      = same && (run_p0 == RUN_ACC);
    assign decoded     = decode_frame(smp_p0);
    assign decoded_bad = any_invalid(decoded);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            smp_p0          <= '0;
            run_p0          <= '0;
            state           <= EMPTY;
            cyc             <= '0;
            seen_step       <= 1'b0;
            chars_p1        <= '0;
            frame_valid_p1  <= 1'b0;
            step_p1         <= 1'b0;
            step_count_p1   <= '0;
            period_p1       <= '0;
            period_valid_p1 <= 1'b0;
            err_p1          <= 1'b0;
            badseg_p1       <= 1'b0;
        end else begin
            // Stage 0: sample and stability qualification
            smp_p0 <= hex_now;
            if (!same) begin
                run_p0 <= '0;
            end else if (run_p0 != RUN_MAX) begin
                run_p0 <= run_p0 + 8'd1;
            end

            // Stage 1: acceptance, classification and step timing
            frame_valid_p1 <= 1'b0;
            step_p1        <= 1'b0;
            if (cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;

            if (accept) begin
                frame_valid_p1 <= 1'b1;
                chars_p1       <= decoded;
                if (decoded_bad) badseg_p1 <= 1'b1;
                case (state)
                    EMPTY: state <= TRACK;
                    TRACK: begin
                        if (decoded == chars_p1) begin
                            state <= TRACK;
                        end else if (decoded == scroll_left(chars_p1)) begin
                            step_p1   <= 1'b1;
                            if (step_count_p1 != 8'hFF) step_count_p1 <= step_count_p1 + 8'd1;
                            period_p1 <= cyc;
                            cyc       <= 32'd1;
                            if (seen_step) period_valid_p1 <= 1'b1;
                            seen_step <= 1'b1;
                        end else begin
                            err_p1 <= 1'b1;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.CHARS        = chars_p1;
    assign bus.FRAME_VALID  = frame_valid_p1;
    assign bus.STEP         = step_p1;
    assign bus.STEP_COUNT   = step_count_p1;
    assign bus.PERIOD       = period_p1;
    assign bus.PERIOD_VALID = period_valid_p1;
    assign bus.ERR          = err_p1;
    assign bus.BADSEG       = badseg_p1;

endmodule
